// File: rtl/rf_write_arbiter_if.sv
// Register-file write port bundle: WB and MC requests in, arbitrated write out.
// master drives the requests, slave is the arbiter.
interface rf_write_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
) ();
    logic          wb_en;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_val;
    logic          mc_valid;
    logic [AW-1:0] mc_dest;
    logic [DW-1:0] mc_val;
    logic          mc_ready;
    logic          pipe_stall;
    logic          rf_write_en;
    logic [AW-1:0] rf_dest;
    logic [DW-1:0] rf_write_val;

    modport master (
        output wb_en, wb_dest, wb_val, mc_valid, mc_dest, mc_val,
        input  mc_ready, pipe_stall, rf_write_en, rf_dest, rf_write_val
    );

    modport slave (
        input  wb_en, wb_dest, wb_val, mc_valid, mc_dest, mc_val,
        output mc_ready, pipe_stall, rf_write_en, rf_dest, rf_write_val
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB (always wins) and a multi-cycle unit.
// Latency 1 to rf_write_*; MC waits via mc_ready, long MC starvation raises pipe_stall.
// Backpressure: mc_ready is combinational; WB is never refused.
module rf_write_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int DW         = 32,
    parameter int AW         = 5
) (
    input  logic               clk,
    input  logic               rst,
    rf_write_arbiter_if.slave  bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic {NORMAL, STALL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blocked;
    logic          accept;

    assign bus.mc_ready   = bus.mc_valid & ~bus.wb_en & rst;
    assign blocked        = bus.mc_valid & bus.wb_en;
    assign accept         = bus.mc_valid & bus.mc_ready;
    assign bus.pipe_stall = (state_q == STALL);

    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        if (blocked) begin
            cnt_d = (cnt_q == CW'(STARVE_MAX)) ? cnt_q : cnt_q + CW'(1);
        end
        case (state_q)
            NORMAL: begin
                if (blocked && (cnt_q == CW'(STARVE_MAX - 1))) state_d = STALL;
            end
            STALL: begin
                // WB keeps winning while stalled; only a drain or a withdrawn request exits.
                if (accept || !bus.mc_valid) state_d = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= NORMAL;
            cnt_q            <= '0;
            bus.rf_write_en  <= 1'b0;
            bus.rf_dest      <= '0;
            bus.rf_write_val <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bus.rf_write_en <= 1'b0;
            // A winner targeting register 0 is consumed but never written.
            if (bus.wb_en) begin
                bus.rf_dest      <= bus.wb_dest;
                bus.rf_write_val <= bus.wb_val;
                bus.rf_write_en  <= (bus.wb_dest != '0);
            end else if (accept) begin
                bus.rf_dest      <= bus.mc_dest;
                bus.rf_write_val <= bus.mc_val;
                bus.rf_write_en  <= (bus.mc_dest != '0);
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed checks of rf_write_arbiter against a run-length starvation model.
module tb_rf_write_arbiter;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.DW(32), .AW(5)) bus ();

    rf_write_arbiter #(.STARVE_MAX(SM), .DW(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: pipe_stall means the most recent SM or more cycles were all blocked.
    int          run      = 0;
    logic        m_en     = 1'b0;
    logic        m_stall  = 1'b0;
    logic        m_known  = 1'b0;
    logic [4:0]  m_dest   = '0;
    logic [31:0] m_val    = '0;
    logic        exp_rdy  = 1'b0;
    logic        rdy_seen = 1'b0;

    task automatic step(input logic r, input logic we, input logic [4:0] wd, input logic [31:0] wv,
                        input logic mv, input logic [4:0] md, input logic [31:0] mvl);
        logic blk;
        rst = r; bus.wb_en = we; bus.wb_dest = wd; bus.wb_val = wv;
        bus.mc_valid = mv; bus.mc_dest = md; bus.mc_val = mvl;
        #1;
        rdy_seen = bus.mc_ready;
        exp_rdy  = r && mv && !we;
        if (!r) begin
            run = 0; m_en = 1'b0; m_stall = 1'b0; m_dest = '0; m_val = '0; m_known = 1'b1;
        end else begin
            blk     = mv && we;
            run     = blk ? run + 1 : 0;
            m_stall = blk && (run >= SM);
            m_en    = 1'b0;
            if (we || exp_rdy) begin
                m_en    = we ? (wd != 0) : (md != 0);
                m_known = m_en;
                if (m_en) begin
                    m_dest = we ? wd : md;
                    m_val  = we ? wv : mvl;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 5'(i + 3), $urandom, 1'b1, 5'd4, $urandom);
            checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", rdy_seen); end
        end
        checks++; if (bus.rf_write_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", bus.rf_write_en); end
        checks++; if (bus.rf_dest !== 5'd0) begin errors++; $display("FAIL reset_dest got %0d want 0", bus.rf_dest); end
        checks++; if (bus.rf_write_val !== 32'd0) begin errors++; $display("FAIL reset_val got %h want 0", bus.rf_write_val); end
        checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.pipe_stall); end
    endtask

    task automatic test_wb_only();
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL wb_only_rdy got %b want 0", rdy_seen); end
        checks++; if (bus.rf_write_en !== 1'b1) begin errors++; $display("FAIL wb_only_en got %b want 1", bus.rf_write_en); end
        checks++; if (bus.rf_dest !== 5'd5) begin errors++; $display("FAIL wb_only_dest got %0d want 5", bus.rf_dest); end
        checks++; if (bus.rf_write_val !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_only_val got %h want deadbeef", bus.rf_write_val); end
    endtask

    task automatic test_mc_only();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h12);
        checks++; if (rdy_seen !== 1'b1) begin errors++; $display("FAIL mc_only_rdy got %b want 1", rdy_seen); end
        checks++; if (bus.rf_write_en !== 1'b1) begin errors++; $display("FAIL mc_only_en got %b want 1", bus.rf_write_en); end
        checks++; if (bus.rf_dest !== 5'd9) begin errors++; $display("FAIL mc_only_dest got %0d want 9", bus.rf_dest); end
        checks++; if (bus.rf_write_val !== 32'h12) begin errors++; $display("FAIL mc_only_val got %h want 12", bus.rf_write_val); end
        idle();
        checks++; if (bus.rf_write_en !== 1'b0) begin errors++; $display("FAIL idle_en got %b want 0", bus.rf_write_en); end
        checks++; if (bus.rf_dest !== 5'd9 || bus.rf_write_val !== 32'h12)
            begin errors++; $display("FAIL idle_hold got %0d/%h want 9/12", bus.rf_dest, bus.rf_write_val); end
    endtask

    task automatic test_starve();
        for (int i = 1; i <= SM; i++) begin
            step(1'b1, 1'b1, 5'd3, 32'(i), 1'b1, 5'd7, 32'h77);
            checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL starve_rdy%0d got %b want 0", i, rdy_seen); end
            checks++; if (bus.pipe_stall !== (i == SM)) begin errors++; $display("FAIL starve_stall%0d got %b want %b", i, bus.pipe_stall, i == SM); end
        end
        step(1'b1, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd7, 32'h77);
        checks++; if (bus.pipe_stall !== 1'b1 || bus.rf_write_val !== 32'hAA || bus.rf_write_en !== 1'b1)
            begin errors++; $display("FAIL stall_wb_wins got %b/%h want 1/aa", bus.pipe_stall, bus.rf_write_val); end
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
        checks++; if (rdy_seen !== 1'b1) begin errors++; $display("FAIL drain_rdy got %b want 1", rdy_seen); end
        checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL drain_stall got %b want 0", bus.pipe_stall); end
        checks++; if (bus.rf_dest !== 5'd7 || bus.rf_write_val !== 32'h77)
            begin errors++; $display("FAIL drain_write got %0d/%h want 7/77", bus.rf_dest, bus.rf_write_val); end
    endtask

    task automatic test_zero_dest();
        step(1'b1, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
        checks++; if (bus.rf_write_en !== 1'b0) begin errors++; $display("FAIL zero_wb_en got %b want 0", bus.rf_write_en); end
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h66);
        checks++; if (rdy_seen !== 1'b1) begin errors++; $display("FAIL zero_mc_rdy got %b want 1", rdy_seen); end
        checks++; if (bus.rf_write_en !== 1'b0) begin errors++; $display("FAIL zero_mc_en got %b want 0", bus.rf_write_en); end
    endtask

    task automatic test_reset_mid_stall();
        for (int i = 0; i < SM; i++) step(1'b1, 1'b1, 5'd2, 32'h1, 1'b1, 5'd11, 32'hB);
        checks++; if (bus.pipe_stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got %b want 1", bus.pipe_stall); end
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB);
        checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL mid_reset_rdy got %b want 0", rdy_seen); end
        checks++; if (bus.pipe_stall !== 1'b0 || bus.rf_write_en !== 1'b0)
            begin errors++; $display("FAIL mid_reset_out got %b/%b want 0/0", bus.pipe_stall, bus.rf_write_en); end
        for (int i = 1; i <= SM; i++) begin
            step(1'b1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hB);
            checks++; if (bus.pipe_stall !== (i == SM)) begin errors++; $display("FAIL restart_stall%0d got %b want %b", i, bus.pipe_stall, i == SM); end
        end
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB);
    endtask

    task automatic test_back_to_back();
        logic acc_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, (i % 2 == 0), 5'(i + 1), 32'(i), 1'b1, 5'd20, 32'(100 + i));
            if (i == 1) acc_seen = rdy_seen;
            checks++; if (bus.pipe_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d got %b want 0", i, bus.pipe_stall); end
        end
        checks++; if (acc_seen !== 1'b1) begin errors++; $display("FAIL b2b_first_accept got %b want 1", acc_seen); end
        idle();
    endtask

    task automatic test_random();
        logic        pv = 1'b0;
        logic [4:0]  pd = '0;
        logic [31:0] pval = '0;
        logic        r, we;
        for (int i = 0; i < 600; i++) begin
            if (!pv && $urandom_range(0, 2) != 0) begin
                pv = 1'b1; pd = 5'($urandom_range(0, 31)); pval = $urandom;
            end else if (pv && $urandom_range(0, 30) == 0) begin
                pv = 1'b0;
            end
            r  = ($urandom_range(0, 60) != 0);
            we = ($urandom_range(0, 99) < 70);
            step(r, we, 5'($urandom_range(0, 31)), $urandom, pv, pd, pval);
            checks++; if (rdy_seen !== exp_rdy) begin errors++; $display("FAIL rnd_rdy@%0d got %b want %b", i, rdy_seen, exp_rdy); end
            checks++; if (bus.rf_write_en !== m_en) begin errors++; $display("FAIL rnd_en@%0d got %b want %b", i, bus.rf_write_en, m_en); end
            checks++; if (bus.pipe_stall !== m_stall) begin errors++; $display("FAIL rnd_stall@%0d got %b want %b", i, bus.pipe_stall, m_stall); end
            if (m_known) begin
                checks++;
                if (bus.rf_dest !== m_dest || bus.rf_write_val !== m_val)
                    begin errors++; $display("FAIL rnd_data@%0d got %0d/%h want %0d/%h", i, bus.rf_dest, bus.rf_write_val, m_dest, m_val); end
            end
            if (exp_rdy) pv = 1'b0;
        end
    endtask

    initial begin
        bus.wb_en = 1'b0; bus.wb_dest = '0; bus.wb_val = '0;
        bus.mc_valid = 1'b0; bus.mc_dest = '0; bus.mc_val = '0;
        #2;
        test_reset();
        test_wb_only();
        test_mc_only();
        test_starve();
        test_zero_dest();
        test_reset_mid_stall();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
